// File: rtl/onehot_pkg.sv
// onehot_pkg
// Shared definitions for one-hot encoders.
//   ENC_OR    : multi-hot lanes encode to the bitwise OR of all set indices
//   ENC_PRIO  : multi-hot lanes encode to the lowest set index
//   bin_width : index width needed for a one-hot vector of the given width
//               (a 1-bit vector still gets a 1-bit index)
package onehot_pkg;

    localparam int ENC_OR   = 0;
    localparam int ENC_PRIO = 1;

    function automatic int bin_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/onehot_enc_lane.sv
// onehot_enc_lane
// Purely combinational encoder for one lane of one-hot bits.
// Ports:
//   onehot : input vector, ONEHOT_WIDTH bits
//   bin    : encoded index (0 when no bit is set)
//   zero   : no bit set
//   multi  : two or more bits set
module onehot_enc_lane
    import onehot_pkg::*;
#(
    parameter int ONEHOT_WIDTH  = 16,
    parameter int PRIORITY_MODE = ENC_OR,
    localparam int BIN_WIDTH    = bin_width(ONEHOT_WIDTH)
) (
    input  logic [ONEHOT_WIDTH-1:0] onehot,
    output logic [BIN_WIDTH-1:0]    bin,
    output logic                    zero,
    output logic                    multi
);

    always_comb begin
        bin   = '0;
        zero  = ~|onehot;
        multi = !$onehot0(onehot);
        if (PRIORITY_MODE == ENC_PRIO) begin
            // Scan from the top so the lowest set index is written last.
            for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
                if (onehot[i]) bin = BIN_WIDTH'(i);
            end
        end else begin
            // For a true one-hot lane the OR is exactly the index.
            for (int i = 0; i < ONEHOT_WIDTH; i++) begin
                if (onehot[i]) bin = bin | BIN_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_to_bin_stream.sv
// onehot_to_bin_stream
// Registered multi-lane one-hot-to-binary encoder on a valid/ready stream,
// with a saturating count of beats that contained a multi-hot lane.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clr_i             : synchronous clear of err_cnt_o only
//   valid_i, ready_o  : input stream handshake
//   onehot_i          : NUM_LANES one-hot vectors, lane 0 in the LSBs
//   valid_o, ready_i  : output stream handshake
//   bin_o             : NUM_LANES encoded indices, lane 0 in the LSBs
//   zero_o, multi_o   : per-lane no-bit-set / several-bits-set flags
//   err_cnt_o         : accepted beats with any multi-hot lane (saturating)
//
// Handshake: a beat transfers on a cycle where valid and ready are both high.
// Once valid_o is raised it stays high with bin_o/zero_o/multi_o stable until
// ready_i is seen; ready_o = !valid_o || ready_i and never looks at valid_i.
module onehot_to_bin_stream
    import onehot_pkg::*;
#(
    parameter int ONEHOT_WIDTH  = 16,
    parameter int NUM_LANES     = 4,
    parameter int PRIORITY_MODE = ENC_OR,
    parameter int CNT_WIDTH     = 16,
    localparam int BIN_WIDTH    = bin_width(ONEHOT_WIDTH)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clr_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [NUM_LANES*ONEHOT_WIDTH-1:0] onehot_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [NUM_LANES*BIN_WIDTH-1:0]    bin_o,
    output logic [NUM_LANES-1:0]              zero_o,
    output logic [NUM_LANES-1:0]              multi_o,
    output logic [CNT_WIDTH-1:0]              err_cnt_o
);

    logic [NUM_LANES*BIN_WIDTH-1:0] lane_bin;
    logic [NUM_LANES-1:0]           lane_zero;
    logic [NUM_LANES-1:0]           lane_multi;
    logic                           accept;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        onehot_enc_lane #(
            .ONEHOT_WIDTH (ONEHOT_WIDTH),
            .PRIORITY_MODE(PRIORITY_MODE)
        ) u_enc (
            .onehot(onehot_i[l*ONEHOT_WIDTH +: ONEHOT_WIDTH]),
            .bin   (lane_bin[l*BIN_WIDTH +: BIN_WIDTH]),
            .zero  (lane_zero[l]),
            .multi (lane_multi[l])
        );
    end

    assign ready_o = !valid_o || ready_i;
    assign accept  = valid_i && ready_o;

    // Output register. A simultaneous in/out handshake simply reloads it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            bin_o   <= '0;
            zero_o  <= '0;
            multi_o <= '0;
        end else if (accept) begin
            valid_o <= 1'b1;
            bin_o   <= lane_bin;
            zero_o  <= lane_zero;
            multi_o <= lane_multi;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // Counts beats, not lanes; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            err_cnt_o <= '0;
        end else if (accept && (|lane_multi) && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_to_bin_stream.sv
// tb_onehot_to_bin_stream
// Three instances share one input stream: OR mode, priority mode, and OR mode
// with a 2-bit error counter. A queue-based stream model predicts every output.
module tb_onehot_to_bin_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i   = 1'b1;
    logic        clr_i   = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [63:0] onehot_i = '0;

    logic        ready0, valid0, ready1, valid1, readyc, validc;
    logic [15:0] bin0, bin1, binc;
    logic [3:0]  zero0, zero1, zeroc, multi0, multi1, multic;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cntc;

    onehot_to_bin_stream #(.ONEHOT_WIDTH(16), .NUM_LANES(4), .PRIORITY_MODE(0), .CNT_WIDTH(16)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .valid_i(valid_i), .ready_o(ready0),
        .onehot_i(onehot_i), .valid_o(valid0), .ready_i(ready_i), .bin_o(bin0),
        .zero_o(zero0), .multi_o(multi0), .err_cnt_o(cnt0));

    onehot_to_bin_stream #(.ONEHOT_WIDTH(16), .NUM_LANES(4), .PRIORITY_MODE(1), .CNT_WIDTH(16)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .valid_i(valid_i), .ready_o(ready1),
        .onehot_i(onehot_i), .valid_o(valid1), .ready_i(ready_i), .bin_o(bin1),
        .zero_o(zero1), .multi_o(multi1), .err_cnt_o(cnt1));

    onehot_to_bin_stream #(.ONEHOT_WIDTH(16), .NUM_LANES(4), .PRIORITY_MODE(0), .CNT_WIDTH(2)) dutc (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .valid_i(valid_i), .ready_o(readyc),
        .onehot_i(onehot_i), .valid_o(validc), .ready_i(ready_i), .bin_o(binc),
        .zero_o(zeroc), .multi_o(multic), .err_cnt_o(cntc));

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    int          exp_cnt16 = 0;
    int          exp_cnt2  = 0;
    int          n_vec     = 0;
    int          n_err     = 0;
    bit          checking  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected encoding of a beat, from bit counts and index arithmetic.
    function automatic void enc(input logic [63:0] beat, input int mode,
                                output logic [15:0] b, output logic [3:0] z,
                                output logic [3:0] m);
        b = '0; z = '0; m = '0;
        for (int l = 0; l < 4; l++) begin
            logic [15:0] v;
            int cnt, idx_or, idx_lo;
            v = beat[l*16 +: 16];
            cnt = 0; idx_or = 0; idx_lo = -1;
            for (int k = 0; k < 16; k++) begin
                if (v[k]) begin
                    cnt++;
                    idx_or = idx_or | k;
                    if (idx_lo < 0) idx_lo = k;
                end
            end
            z[l] = (cnt == 0);
            m[l] = (cnt > 1);
            if (cnt > 0) b[l*4 +: 4] = 4'((mode == 1) ? idx_lo : idx_or);
        end
    endfunction

    // Stream model: a one-deep queue of accepted beats plus error counters.
    always @(posedge clk) begin : model
        logic [15:0] b;
        logic [3:0]  z, m;
        bit          acc, pop;
        if (rst_i) begin
            exp_q.delete();
            exp_cnt16 = 0;
            exp_cnt2  = 0;
        end else begin
            acc = valid_i && ((exp_q.size() == 0) || ready_i);
            pop = (exp_q.size() != 0) && ready_i;
            enc(onehot_i, 0, b, z, m);
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(onehot_i);
            if (clr_i) begin
                exp_cnt16 = 0;
                exp_cnt2  = 0;
            end else if (acc && (|m)) begin
                if (exp_cnt16 < 65535) exp_cnt16++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
    end

    // Compare process: every negedge once reset has been applied.
    always @(negedge clk) begin : compare
        logic [15:0] b;
        logic [3:0]  z, m;
        logic        exp_rdy, exp_vld;
        if (checking) begin
            exp_vld = (exp_q.size() != 0);
            exp_rdy = !exp_vld || ready_i;
            chk("ready0", 64'(ready0), 64'(exp_rdy));
            chk("ready1", 64'(ready1), 64'(exp_rdy));
            chk("readyc", 64'(readyc), 64'(exp_rdy));
            chk("valid0", 64'(valid0), 64'(exp_vld));
            chk("valid1", 64'(valid1), 64'(exp_vld));
            chk("validc", 64'(validc), 64'(exp_vld));
            if (exp_vld) begin
                enc(exp_q[0], 0, b, z, m);
                chk("bin0", 64'(bin0), 64'(b));
                chk("zero0", 64'(zero0), 64'(z));
                chk("multi0", 64'(multi0), 64'(m));
                chk("binc", 64'(binc), 64'(b));
                enc(exp_q[0], 1, b, z, m);
                chk("bin1", 64'(bin1), 64'(b));
                chk("zero1", 64'(zero1), 64'(z));
                chk("multi1", 64'(multi1), 64'(m));
            end
            chk("cnt0", 64'(cnt0), 64'(exp_cnt16));
            chk("cnt1", 64'(cnt1), 64'(exp_cnt16));
            chk("cntc", 64'(cntc), 64'(exp_cnt2));
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit v, input logic [63:0] oh, input bit rdy,
                        input bit clr, input bit rst);
        @(posedge clk);
        #2;
        valid_i  = v;
        onehot_i = oh;
        ready_i  = rdy;
        clr_i    = clr;
        rst_i    = rst;
    endtask

    function automatic logic [63:0] rand_beat();
        logic [63:0] b;
        b = '0;
        for (int l = 0; l < 4; l++) begin
            case ($urandom_range(0, 3))
                0:       b[l*16 +: 16] = 16'h0;
                1, 2:    b[l*16 +: 16] = 16'h1 << $urandom_range(0, 15);
                default: b[l*16 +: 16] = 16'($urandom());
            endcase
        end
        return b;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2;
        checking = 1'b1;

        // Reset values while reset is still held.
        @(negedge clk);
        chk("rst_valid", 64'(valid0), 64'h0);
        chk("rst_bin", 64'(bin0), 64'h0);
        chk("rst_zero", 64'(zero0), 64'h0);
        chk("rst_multi", 64'(multi0), 64'h0);
        chk("rst_cnt", 64'(cnt0), 64'h0);
        chk("rst_ready", 64'(ready0), 64'h1);

        // First beat: lane3..lane0 = 8000, 0000, 0001, 0020.
        step(1, 64'h8000_0000_0001_0020, 1, 0, 0);
        step(0, 64'h0, 1, 0, 0);
        @(negedge clk);
        chk("first_valid", 64'(valid0), 64'h1);
        chk("first_bin", 64'(bin0), 64'hF005);
        chk("first_zero", 64'(zero0), 64'h4);
        chk("first_multi", 64'(multi0), 64'h0);
        chk("first_cnt", 64'(cnt0), 64'h0);

        // Multi-hot 0x0028 on lane0: OR gives 7, lowest index gives 3.
        step(1, 64'h0000_0000_0000_0028, 1, 0, 0);
        step(0, 64'h0, 1, 0, 0);
        @(negedge clk);
        chk("or_bin", 64'(bin0), 64'h0007);
        chk("or_multi", 64'(multi0), 64'h1);
        chk("or_cnt", 64'(cnt0), 64'h1);
        chk("prio_bin", 64'(bin1), 64'h0003);
        chk("prio_multi", 64'(multi1), 64'h1);

        // Stall for 5 cycles with changing data; the first beat must hold.
        step(1, {4{16'h0004}}, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, rand_beat(), 0, 0, 0);
        @(negedge clk);
        chk("stall_bin", 64'(bin0), 64'h2222);
        chk("stall_ready", 64'(ready0), 64'h0);
        for (int i = 0; i < 4; i++) step(1, rand_beat(), 1, 0, 0);
        step(0, 64'h0, 1, 0, 0);
        step(0, 64'h0, 1, 0, 0);

        // Back-to-back: lane0 walks bits 0..7, no bubbles.
        for (int i = 0; i <= 8; i++) begin
            step(i < 8, (i < 8) ? (64'h1 << i) : 64'h0, 1, 0, 0);
            if (i > 0) begin
                @(negedge clk);
                chk("b2b_valid", 64'(valid0), 64'h1);
                chk("b2b_bin", 64'(bin0[3:0]), 64'(i - 1));
            end
        end

        // Saturation of the 2-bit counter: 1,2,3,3,3.
        step(0, 64'h0, 1, 1, 0);
        for (int i = 0; i <= 5; i++) begin
            step(i < 5, 64'h3, 1, 0, 0);
            if (i > 0) begin
                @(negedge clk);
                chk("sat_cnt", 64'(cntc), 64'((i < 3) ? i : 3));
            end
        end
        // Clear coincident with a multi-hot beat wins.
        step(1, 64'h3, 1, 1, 0);
        step(0, 64'h0, 1, 0, 0);
        @(negedge clk);
        chk("clr_cntc", 64'(cntc), 64'h0);
        chk("clr_cnt0", 64'(cnt0), 64'h0);

        // Reset during a stall drops the held beat and the count.
        step(1, 64'h3, 0, 0, 0);
        step(0, 64'h0, 0, 0, 0);
        @(negedge clk);
        chk("held_valid", 64'(valid0), 64'h1);
        chk("held_cnt", 64'(cnt0), 64'h1);
        step(0, 64'h0, 0, 0, 1);
        step(0, 64'h0, 1, 0, 0);
        @(negedge clk);
        chk("rst_stall_valid", 64'(valid0), 64'h0);
        chk("rst_stall_cnt", 64'(cnt0), 64'h0);
        step(0, 64'h0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
        end
        step(0, 64'h0, 1, 0, 0);
        step(0, 64'h0, 1, 0, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
